// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter granting atomic write bursts from two requesters to one FIFO port
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5,
    parameter int MAX_BURST  = 8,
    localparam int LEN_WIDTH = $clog2(MAX_BURST) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [LEN_WIDTH-1:0]  len0,
    input  logic [LEN_WIDTH-1:0]  len1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  take0,
    output logic                  take1,
    output logic                  done0,
    output logic                  done1,
    output logic                  fifo_wren,
    output logic [DATA_WIDTH-1:0] fifo_wrdata,
    input  logic                  fifo_wrdone,
    input  logic [CNT_WIDTH-1:0]  fifo_num_free
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 sel_q, sel_d;
    logic                 last_q, last_d;
    logic                 el0, el1, pick1, busy;

    assign el0   = req0 && len0 != '0 && int'(len0) <= MAX_BURST && int'(len0) <= int'(fifo_num_free);
    assign el1   = req1 && len1 != '0 && int'(len1) <= MAX_BURST && int'(len1) <= int'(fifo_num_free);
    assign pick1 = el1 && (!el0 || !last_q);
    assign busy  = state_q == WRITE || state_q == DONE;

    assign gnt0        = busy && !sel_q;
    assign gnt1        = busy && sel_q;
    assign fifo_wren   = state_q == WRITE;
    assign fifo_wrdata = fifo_wren ? (sel_q ? data1 : data0) : '0;
    assign take0       = gnt0 && fifo_wren && fifo_wrdone;
    assign take1       = gnt1 && fifo_wren && fifo_wrdone;
    assign done0       = gnt0 && state_q == DONE;
    assign done1       = gnt1 && state_q == DONE;

    // arbitrate in IDLE, count down acknowledged words in WRITE, one-cycle DONE before returning
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (el0 || el1) begin
                state_d = WRITE;
                sel_d   = pick1;
                last_d  = pick1;
                rem_d   = pick1 ? len1 : len0;
            end
        end else if (state_q == WRITE) begin
            if (fifo_wrdone) begin
                rem_d   = rem_q - LEN_WIDTH'(1);
                state_d = rem_q == LEN_WIDTH'(1) ? DONE : WRITE;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // state registers; pointer resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for the two-requester FIFO write arbiter
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int CW = 5;
    localparam int MB = 8;
    localparam int LW = 4;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, take0, take1, done0, done1, fifo_wren;
    logic [DW-1:0] fifo_wrdata;
    logic          fifo_wrdone = 1'b0;
    logic [CW-1:0] fifo_num_free = '0;

    exp_t sb[$];
    exp_t e;
    int   vecs = 0, errs = 0, ntake0 = 0, ntake1 = 0, wd_delay = 0, wd_cnt = 0;
    bit   stray = 1'b0, pend0 = 1'b0, pend1 = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .take0(take0), .take1(take1),
        .done0(done0), .done1(done1),
        .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
        .fifo_wrdone(fifo_wrdone), .fifo_num_free(fifo_num_free)
    );

    // requester/FIFO model: advance data after a take, pace fifo_wrdone, score every take pulse
    always begin
        @(negedge clk);
        if (pend0) data0 = data0 + 8'h11;
        if (pend1) data1 = data1 + 8'h11;
        pend0 = 1'b0;
        pend1 = 1'b0;
        if (fifo_wren && wd_cnt >= wd_delay) begin
            fifo_wrdone = 1'b1;
            wd_cnt = 0;
        end else begin
            fifo_wrdone = stray && !fifo_wren;
            wd_cnt = fifo_wren ? wd_cnt + 1 : 0;
        end
        #1;
        vecs++;
        if ((gnt0 && gnt1) || (take0 && !gnt0) || (take1 && !gnt1) || (done0 && !gnt0) || (done1 && !gnt1)) begin
            errs++;
            $display("FAIL exclusivity: gnt=%b%b take=%b%b done=%b%b, required single grant covering take/done",
                     gnt0, gnt1, take0, take1, done0, done1);
        end
        if (take0 || take1) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_take: id=%0d data=%h, required no write", take1, fifo_wrdata);
            end else begin
                e = sb.pop_front();
                if (take1 !== e.id || fifo_wrdata !== e.d) begin
                    errs++;
                    $display("FAIL write_data: id=%0d data=%h, required id=%0d data=%h", take1, fifo_wrdata, e.id, e.d);
                end
            end
            if (take0) ntake0++;
            if (take1) ntake1++;
            pend0 = take0;
            pend1 = take1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_words(input logic id, input logic [DW-1:0] base, input int cnt);
        logic [DW-1:0] w;
        w = base;
        for (int k = 0; k < cnt; k++) begin
            sb.push_back('{id: id, d: w});
            w = w + 8'h11;
        end
    endtask

    task automatic wait_done(input bit id, input int budget, output int n);
        n = 0;
        while (!(id ? done1 : done0) && n < budget) begin
            tick();
            n++;
        end
        vecs++;
        if (!(id ? done1 : done0)) begin
            errs++;
            $display("FAIL done%0d_timeout: none after %0d cycles, required a done pulse", id, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        vecs++;
        if ({gnt0, gnt1, take0, take1, done0, done1, fifo_wren} !== 7'b0 || fifo_wrdata !== '0) begin
            errs++;
            $display("FAIL reset_outputs: gnt=%b%b wren=%b data=%h, required all zero", gnt0, gnt1, fifo_wren, fifo_wrdata);
        end
        reset = 1'b0;
        stray = 1'b1;
        repeat (3) begin
            tick();
            vecs++;
            if ({gnt0, gnt1, fifo_wren} !== 3'b0) begin
                errs++;
                $display("FAIL stray_wrdone: gnt=%b%b wren=%b, required 000", gnt0, gnt1, fifo_wren);
            end
        end
        stray = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        int n;
        data0 = 8'h20;
        data1 = 8'h80;
        push_words(0, 8'h20, 2);
        push_words(1, 8'h80, 2);
        push_words(0, 8'h42, 2);
        len0 = 2; len1 = 2; fifo_num_free = 16;
        req0 = 1; req1 = 1;
        tick();
        vecs++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errs++;
            $display("FAIL tie_first: gnt=%b%b, required 10", gnt0, gnt1);
        end
        wait_done(0, 10, n);
        tick();
        vecs++;
        if ({gnt0, gnt1, fifo_wren} !== 3'b0) begin
            errs++;
            $display("FAIL tie_gap1: gnt=%b%b wren=%b, required idle", gnt0, gnt1, fifo_wren);
        end
        tick();
        vecs++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            errs++;
            $display("FAIL tie_second: gnt=%b%b, required 01", gnt0, gnt1);
        end
        wait_done(1, 10, n);
        tick();
        vecs++;
        if ({gnt0, gnt1, fifo_wren} !== 3'b0) begin
            errs++;
            $display("FAIL tie_gap2: gnt=%b%b wren=%b, required idle", gnt0, gnt1, fifo_wren);
        end
        tick();
        vecs++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errs++;
            $display("FAIL tie_third: gnt=%b%b, required 10", gnt0, gnt1);
        end
        wait_done(0, 10, n);
        req0 = 0; req1 = 0;
        repeat (2) tick();
        vecs++;
        if ({gnt0, gnt1} !== 2'b0) begin
            errs++;
            $display("FAIL tie_release: gnt=%b%b, required 00", gnt0, gnt1);
        end
    endtask

    task automatic test_single();
        int n, t0;
        data0 = 8'h10;
        push_words(0, 8'h10, 3);
        t0 = ntake0;
        fifo_num_free = 16; len0 = 3; req0 = 1;
        tick();
        vecs++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || fifo_wren !== 1'b1) begin
            errs++;
            $display("FAIL single_grant: gnt=%b%b wren=%b, required 10 1", gnt0, gnt1, fifo_wren);
        end
        req0 = 0; len0 = 7;
        wait_done(0, 20, n);
        vecs++;
        if (n != 3 || ntake0 - t0 != 3) begin
            errs++;
            $display("FAIL single_count: done after %0d cycles with %0d takes, required 3 and 3", n, ntake0 - t0);
        end
        vecs++;
        if (fifo_wren !== 1'b0 || gnt0 !== 1'b1 || fifo_wrdata !== '0) begin
            errs++;
            $display("FAIL single_done_state: wren=%b gnt0=%b data=%h, required 0 1 00", fifo_wren, gnt0, fifo_wrdata);
        end
        tick();
        vecs++;
        if (gnt0 !== 1'b0 || done0 !== 1'b0) begin
            errs++;
            $display("FAIL single_release: gnt0=%b done0=%b, required 0 0", gnt0, done0);
        end
    endtask

    task automatic test_space();
        int n, t1;
        data1 = 8'h50;
        push_words(1, 8'h50, 5);
        t1 = ntake1;
        req1 = 1; len1 = 5; fifo_num_free = 4;
        repeat (4) begin
            tick();
            vecs++;
            if (gnt1 !== 1'b0) begin
                errs++;
                $display("FAIL space_block: gnt1=%b, required 0", gnt1);
            end
        end
        fifo_num_free = 5;
        tick();
        vecs++;
        if (gnt1 !== 1'b1) begin
            errs++;
            $display("FAIL space_grant: gnt1=%b, required 1", gnt1);
        end
        fifo_num_free = 0; req1 = 0;
        wait_done(1, 20, n);
        vecs++;
        if (ntake1 - t1 != 5) begin
            errs++;
            $display("FAIL space_count: takes=%0d, required 5", ntake1 - t1);
        end
        tick();
    endtask

    task automatic test_slow();
        int n, t0;
        wd_delay = 3;
        data0 = 8'h30;
        push_words(0, 8'h30, 2);
        t0 = ntake0;
        len0 = 2; fifo_num_free = 16; req0 = 1;
        tick();
        req0 = 0;
        n = 0;
        while (!done0 && n < 20) begin
            vecs++;
            if (fifo_wren !== 1'b1 || gnt0 !== 1'b1 || fifo_wrdata !== data0) begin
                errs++;
                $display("FAIL slow_hold: wren=%b gnt0=%b data=%h, required 1 1 %h", fifo_wren, gnt0, fifo_wrdata, data0);
            end
            tick();
            n++;
        end
        vecs++;
        if (n != 8 || ntake0 - t0 != 2) begin
            errs++;
            $display("FAIL slow_count: done after %0d cycles with %0d takes, required 8 and 2", n, ntake0 - t0);
        end
        wd_delay = 0;
        tick();
    endtask

    task automatic test_illegal();
        int n, t0;
        fifo_num_free = 16; req0 = 1; len0 = 0;
        repeat (3) begin
            tick();
            vecs++;
            if ({gnt0, gnt1} !== 2'b0) begin
                errs++;
                $display("FAIL len_zero: gnt=%b%b, required 00", gnt0, gnt1);
            end
        end
        len0 = 9;
        repeat (3) begin
            tick();
            vecs++;
            if ({gnt0, gnt1} !== 2'b0) begin
                errs++;
                $display("FAIL len_nine: gnt=%b%b, required 00", gnt0, gnt1);
            end
        end
        data1 = 8'hC0;
        push_words(1, 8'hC0, 1);
        req1 = 1; len1 = 1;
        tick();
        vecs++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errs++;
            $display("FAIL len_one_grant: gnt=%b%b, required 01", gnt0, gnt1);
        end
        req1 = 0;
        wait_done(1, 10, n);
        tick();
        data0 = 8'h01;
        push_words(0, 8'h01, 8);
        t0 = ntake0;
        len0 = 8; fifo_num_free = 8;
        tick();
        vecs++;
        if (gnt0 !== 1'b1) begin
            errs++;
            $display("FAIL max_burst_grant: gnt0=%b, required 1", gnt0);
        end
        req0 = 0;
        wait_done(0, 30, n);
        vecs++;
        if (ntake0 - t0 != 8) begin
            errs++;
            $display("FAIL max_burst_count: takes=%0d, required 8", ntake0 - t0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n, t0;
        data0 = 8'h60;
        push_words(0, 8'h60, 4);
        len0 = 4; fifo_num_free = 16; req0 = 1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        vecs++;
        if ({gnt0, gnt1, take0, take1, done0, done1, fifo_wren} !== 7'b0 || fifo_wrdata !== '0) begin
            errs++;
            $display("FAIL reset_mid_outputs: gnt=%b%b take=%b%b wren=%b data=%h, required all zero",
                     gnt0, gnt1, take0, take1, fifo_wren, fifo_wrdata);
        end
        sb.delete();
        pend0 = 1'b0;
        data0 = 8'hA0;
        tick();
        vecs++;
        if ({gnt0, fifo_wren} !== 2'b0) begin
            errs++;
            $display("FAIL reset_hold: gnt0=%b wren=%b, required 00", gnt0, fifo_wren);
        end
        reset = 1'b0;
        push_words(0, 8'hA0, 4);
        t0 = ntake0;
        tick();
        vecs++;
        if (gnt0 !== 1'b1) begin
            errs++;
            $display("FAIL reset_rearb: gnt0=%b, required 1", gnt0);
        end
        req0 = 0;
        wait_done(0, 20, n);
        vecs++;
        if (ntake0 - t0 != 4) begin
            errs++;
            $display("FAIL reset_fresh_count: takes=%0d, required 4", ntake0 - t0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_space();
        test_slow();
        test_illegal();
        test_reset_mid();
        vecs++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_leftover: %0d words unwritten, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
